array_0_access_ctrl: RTL and testbench
======================================

Name: array_0_access_ctrl

Overview:
Access controller placed directly in front of the 32x25 masked SRAM macro array_0_ext. On reset it runs a clear sweep over all entries. It then accepts independent write and read requests with valid/ready handshakes and drives the macro's R0/W0 ports. It turns the macro's one-cycle read into a registered, back-pressurable response stream. The integrating parent ties the macro's R0_clk and W0_clk to clock.

Parameters:
DEPTH, 32, number of entries.
ADDR_W, 5, address width, equal to log2(DEPTH).
DATA_W, 25, entry width.
INIT_VALUE, 0, value written to every entry during the clear sweep.

Ports:
clock  input  1  single clock for the block and the macro.
reset_n  input  1  asynchronous, active-low reset.
init_done  output  1  high once the clear sweep has finished.
wr_valid  input  1  write request.
wr_ready  output  1  write accepted when wr_valid and wr_ready are both high.
wr_addr  input  ADDR_W  write address.
wr_data  input  DATA_W  write data.
rd_req_valid  input  1  read request.
rd_req_ready  output  1  read request accepted when both are high.
rd_req_addr  input  ADDR_W  read address.
rd_resp_valid  output  1  read response valid.
rd_resp_ready  input  1  consumer accepts the response.
rd_resp_data  output  DATA_W  read response data.
sram_r_en  output  1  to macro R0_en.
sram_r_addr  output  ADDR_W  to macro R0_addr.
sram_r_data  input  DATA_W  from macro R0_data; valid the cycle after sram_r_en.
sram_w_en  output  1  to macro W0_en.
sram_w_addr  output  ADDR_W  to macro W0_addr.
sram_w_data  output  DATA_W  to macro W0_data.
sram_w_mask  output  1  to macro W0_mask; held at 1 at all times.

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-low. All state is cleared immediately on reset_n low, including when reset arrives mid-sweep or mid-read.
- Reset values: init_done=0, wr_ready=0, rd_req_ready=0, rd_resp_valid=0, rd_resp_data=0, sram_r_en=0, sram_w_en=0. The FSM is in INIT, the sweep counter is 0, and s1_valid and s1_fwd_valid are 0.
- FSM state INIT:
  - Each cycle: sram_w_en=1, sram_w_addr=counter, sram_w_data=INIT_VALUE; counter increments.
  - After the write at DEPTH-1, the FSM moves to RUN. The sweep takes exactly DEPTH cycles after reset release.
  - wr_ready and rd_req_ready are 0 throughout INIT.
- FSM state RUN: init_done=1. RUN is left only by reset.
- Write path:
  - wr_ready=1 in RUN.
  - On a write handshake: sram_w_en=1 with wr_addr and wr_data in the same cycle, combinationally.
  - Writes are never stalled by reads.
- Read pipeline:
  - Stage s1 holds the issued address in s1_addr and flag s1_valid.
  - The output register drives rd_resp_valid and rd_resp_data.
  - out_free = !rd_resp_valid || rd_resp_ready.
  - rd_req_ready = RUN && (!s1_valid || out_free).
  - On a read handshake: sram_r_en=1 and sram_r_addr=rd_req_addr in the same cycle; s1_valid is set at the edge.
  - When s1_valid && out_free: the output register loads (s1_fwd_valid ? s1_fwd_data : sram_r_data) and rd_resp_valid is set. s1_valid clears unless a new read is accepted in the same cycle.
  - When out_free and s1 is empty: rd_resp_valid clears on the consume.
  - Latency: handshake at cycle T gives rd_resp_valid at T+2.
  - Throughput is 1 per cycle while rd_resp_ready stays high.
- Stall:
  - When s1_valid && !out_free, s1 holds and sram_r_en=0. The macro keeps its latched address, so sram_r_data stays stable.
  - If a write handshake hits s1_addr while s1 is held: s1_fwd_valid=1 and s1_fwd_data=wr_data, latest write wins.
  - s1_fwd_valid clears when s1 drains or reloads.
- Same-cycle read and write to the same address at accept: the macro latches the address on the same edge as the write, so the response returns the new data (write-first). No forwarding is needed in this case.
- rd_resp_data holds stable while rd_resp_valid && !rd_resp_ready.
- Address arithmetic: no wrap beyond DEPTH. The sweep counter stops at DEPTH-1.

Test Plan:
- Release reset: sram_w_en high for exactly 32 cycles on addresses 0..31 with data 0; init_done rises on cycle 32; reading addresses 0, 17 and 31 returns 0.
- Write addr 5 = 0x1ABCDEF, then read 5 with rd_resp_ready=1 -> rd_resp_valid exactly 2 cycles after the handshake, data 0x1ABCDEF.
- Back-to-back reads of addresses 1,2,3,4 (preloaded 0x11,0x22,0x33,0x44) with rd_resp_ready=1 -> four consecutive valid responses in order, no bubbles.
- Hold rd_resp_ready=0 during that stream -> rd_req_ready drops once s1 and the output are both full; data stays stable; releasing rd_resp_ready delivers all four, none lost or duplicated.
- Stall with s1 holding a read of addr 9 (old 0x5); write 9 = 0x7 then 9 = 0x8 -> response 0x8. Same-cycle read and write of addr 12 = 0x3 -> response 0x3.
- Assert reset_n low at sweep address 10 -> outputs return to reset values immediately; after release the sweep restarts at 0 and takes a full 32 cycles.

Source files
------------

// File: rtl/array_0_access_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : array_0_access_ctrl
//  Purpose  : Access controller in front of the 32x25 masked SRAM macro
//             array_0_ext. After reset it sweeps INIT_VALUE into every entry,
//             then serves independent write and read requests. The macro's
//             one-cycle read becomes a registered, back-pressurable response.
//  Ports    : clock, reset_n        - clock, async active-low reset
//             init_done             - clear sweep finished
//             wr_*                  - write request (valid/ready)
//             rd_req_*              - read request (valid/ready)
//             rd_resp_*             - read response (valid/ready)
//             sram_r_* / sram_w_*   - macro R0 / W0 ports
//  Revision : 1.0 - initial release
// ============================================================================
module array_0_access_ctrl #(
    parameter int                 DEPTH      = 32,
    parameter int                 ADDR_W     = 5,
    parameter int                 DATA_W     = 25,
    parameter logic [DATA_W-1:0]  INIT_VALUE = '0
) (
    input  logic              clock,
    input  logic              reset_n,
    output logic              init_done,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_req_valid,
    output logic              rd_req_ready,
    input  logic [ADDR_W-1:0] rd_req_addr,
    output logic              rd_resp_valid,
    input  logic              rd_resp_ready,
    output logic [DATA_W-1:0] rd_resp_data,
    output logic              sram_r_en,
    output logic [ADDR_W-1:0] sram_r_addr,
    input  logic [DATA_W-1:0] sram_r_data,
    output logic              sram_w_en,
    output logic [ADDR_W-1:0] sram_w_addr,
    output logic [DATA_W-1:0] sram_w_data,
    output logic              sram_w_mask
);

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;

    logic                s1_valid_q, s1_valid_d;
    logic [ADDR_W-1:0]   s1_addr_q, s1_addr_d;
    logic                s1_fwd_valid_q, s1_fwd_valid_d;
    logic [DATA_W-1:0]   s1_fwd_data_q, s1_fwd_data_d;

    logic                resp_valid_q, resp_valid_d;
    logic [DATA_W-1:0]   resp_data_q, resp_data_d;

    logic                w_run;
    logic                w_init_active;
    logic                w_out_free;
    logic                w_rd_fire;
    logic                w_wr_fire;
    logic                w_s1_adv;

    // ------------------------------------------------------------------------
    // Control FSM: INIT sweeps the array once, RUN is held until reset.
    // ------------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == ST_INIT) begin
            if (cnt_q == LAST_ADDR) begin
                state_d = ST_RUN;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    assign w_run     = (state_q == ST_RUN);
    assign init_done = w_run;

    // The sweep write is qualified with reset_n so the macro sees no write
    // while reset is held, even though the FSM already sits in INIT.
    assign w_init_active = (state_q == ST_INIT) && reset_n;

    // ------------------------------------------------------------------------
    // Handshakes
    // ------------------------------------------------------------------------
    assign w_out_free   = !resp_valid_q || rd_resp_ready;
    assign wr_ready     = w_run;
    assign rd_req_ready = w_run && (!s1_valid_q || w_out_free);
    assign w_wr_fire    = wr_valid && wr_ready;
    assign w_rd_fire    = rd_req_valid && rd_req_ready;
    assign w_s1_adv     = s1_valid_q && w_out_free;

    // ------------------------------------------------------------------------
    // Macro ports
    // ------------------------------------------------------------------------
    assign sram_w_en   = w_init_active || w_wr_fire;
    assign sram_w_addr = w_init_active ? cnt_q : wr_addr;
    assign sram_w_data = w_init_active ? INIT_VALUE : wr_data;
    assign sram_w_mask = 1'b1;

    // Read enable only on an accepted request: while s1 is stalled the macro
    // keeps its latched address and sram_r_data stays put.
    assign sram_r_en   = w_rd_fire;
    assign sram_r_addr = rd_req_addr;

    // ------------------------------------------------------------------------
    // Read pipeline: s1 (address in flight) -> output register
    // ------------------------------------------------------------------------
    always_comb begin
        s1_valid_d     = s1_valid_q;
        s1_addr_d      = s1_addr_q;
        s1_fwd_valid_d = s1_fwd_valid_q;
        s1_fwd_data_d  = s1_fwd_data_q;
        resp_valid_d   = resp_valid_q;
        resp_data_d    = resp_data_q;

        if (w_s1_adv) begin
            resp_valid_d = 1'b1;
            resp_data_d  = s1_fwd_valid_q ? s1_fwd_data_q : sram_r_data;
        end else if (w_out_free) begin
            resp_valid_d = 1'b0;
        end

        if (w_rd_fire) begin
            // Same-cycle write to this address is write-first in the macro,
            // so a fresh s1 never needs forwarding.
            s1_valid_d     = 1'b1;
            s1_addr_d      = rd_req_addr;
            s1_fwd_valid_d = 1'b0;
        end else if (w_s1_adv) begin
            s1_valid_d     = 1'b0;
            s1_fwd_valid_d = 1'b0;
        end else if (s1_valid_q && w_wr_fire && (wr_addr == s1_addr_q)) begin
            // The macro's read data was captured before this write; hold the
            // newer value aside so the stalled response is not stale.
            s1_fwd_valid_d = 1'b1;
            s1_fwd_data_d  = wr_data;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid_q     <= 1'b0;
            s1_addr_q      <= '0;
            s1_fwd_valid_q <= 1'b0;
            s1_fwd_data_q  <= '0;
            resp_valid_q   <= 1'b0;
            resp_data_q    <= '0;
        end else begin
            s1_valid_q     <= s1_valid_d;
            s1_addr_q      <= s1_addr_d;
            s1_fwd_valid_q <= s1_fwd_valid_d;
            s1_fwd_data_q  <= s1_fwd_data_d;
            resp_valid_q   <= resp_valid_d;
            resp_data_q    <= resp_data_d;
        end
    end

    assign rd_resp_valid = resp_valid_q;
    assign rd_resp_data  = resp_data_q;

endmodule
`default_nettype wire

// File: tb/tb_array_0_access_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_array_0_access_ctrl
//  Purpose  : Scoreboard bench for array_0_access_ctrl with a behavioural
//             model of the array_0_ext macro (registered, write-first read).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_array_0_access_ctrl;

    localparam int AW = 5;
    localparam int DW = 25;

    logic          clock = 1'b0;
    logic          reset_n;
    logic          init_done;
    logic          wr_valid;
    logic          wr_ready;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          rd_req_valid;
    logic          rd_req_ready;
    logic [AW-1:0] rd_req_addr;
    logic          rd_resp_valid;
    logic          rd_resp_ready;
    logic [DW-1:0] rd_resp_data;
    logic          sram_r_en;
    logic [AW-1:0] sram_r_addr;
    logic [DW-1:0] sram_r_data;
    logic          sram_w_en;
    logic [AW-1:0] sram_w_addr;
    logic [DW-1:0] sram_w_data;
    logic          sram_w_mask;

    array_0_access_ctrl dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .init_done     (init_done),
        .wr_valid      (wr_valid),
        .wr_ready      (wr_ready),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .rd_req_valid  (rd_req_valid),
        .rd_req_ready  (rd_req_ready),
        .rd_req_addr   (rd_req_addr),
        .rd_resp_valid (rd_resp_valid),
        .rd_resp_ready (rd_resp_ready),
        .rd_resp_data  (rd_resp_data),
        .sram_r_en     (sram_r_en),
        .sram_r_addr   (sram_r_addr),
        .sram_r_data   (sram_r_data),
        .sram_w_en     (sram_w_en),
        .sram_w_addr   (sram_w_addr),
        .sram_w_data   (sram_w_data),
        .sram_w_mask   (sram_w_mask)
    );

    always #5 clock = ~clock;

    // Macro model: read data registered on R0_en and held otherwise;
    // a write to the address being read on the same edge returns new data.
    logic [DW-1:0] mem [32];
    logic [DW-1:0] r_rdata = '0;
    assign sram_r_data = r_rdata;

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 25'h1555555 ^ DW'(i);
    end

    always @(posedge clock) begin
        if (sram_r_en)
            r_rdata <= (sram_w_en && sram_w_mask && sram_w_addr == sram_r_addr)
                       ? sram_w_data : mem[sram_r_addr];
        if (sram_w_en && sram_w_mask)
            mem[sram_w_addr] <= sram_w_data;
    end

    int            tests = 0;
    int            fails = 0;
    int            cyc   = 0;
    int            pops  = 0;
    logic [DW-1:0] sb[$];
    int            pop_cyc[$];

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every consumed response is matched against the scoreboard.
    always @(negedge clock) begin
        if (reset_n && rd_resp_valid && rd_resp_ready) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_resp: got 0x%0h expected none", rd_resp_data);
            end else begin
                chk("rd_resp_data", 32'(rd_resp_data), 32'(sb.pop_front()));
                pops++;
                pop_cyc.push_back(cyc);
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
        wr_valid = 1'b1;
        wr_addr  = a;
        wr_data  = d;
        tick();
        wr_valid = 1'b0;
    endtask

    // Optional simultaneous write (we=1) in the accept cycle of the read.
    task automatic rw(input logic [AW-1:0] ra, input logic [DW-1:0] exp,
                      input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd);
        int n;
        n = 0;
        rd_req_valid = 1'b1;
        rd_req_addr  = ra;
        wr_valid     = we;
        wr_addr      = wa;
        wr_data      = wd;
        @(negedge clock);
        while (!rd_req_ready && n < 100) begin
            n++;
            @(negedge clock);
        end
        if (n >= 100) begin
            chk("rd_req_ready_timeout", 32'(n), 32'd0);
        end else begin
            sb.push_back(exp);
        end
        tick();
        rd_req_valid = 1'b0;
        wr_valid     = 1'b0;
    endtask

    task automatic rd(input logic [AW-1:0] a, input logic [DW-1:0] exp);
        rw(a, exp, 1'b0, '0, '0);
    endtask

    task automatic wait_pops(input int target, input string name);
        int n;
        n = 0;
        while (pops < target && n < 60) begin
            n++;
            tick();
        end
        chk(name, 32'(pops), 32'(target));
    endtask

    initial begin
        int p0;
        int n;
        reset_n       = 1'b0;
        wr_valid      = 1'b0;
        wr_addr       = '0;
        wr_data       = '0;
        rd_req_valid  = 1'b0;
        rd_req_addr   = '0;
        rd_resp_ready = 1'b1;

        // Reset values
        repeat (3) @(negedge clock);
        chk("rst_init_done", 32'(init_done), 0);
        chk("rst_wr_ready", 32'(wr_ready), 0);
        chk("rst_rd_req_ready", 32'(rd_req_ready), 0);
        chk("rst_resp_valid", 32'(rd_resp_valid), 0);
        chk("rst_resp_data", 32'(rd_resp_data), 0);
        chk("rst_sram_r_en", 32'(sram_r_en), 0);
        chk("rst_sram_w_en", 32'(sram_w_en), 0);

        // Clear sweep: one write per cycle to 0..31, data 0
        reset_n = 1'b1;
        #1;
        for (int i = 0; i < 32; i++) begin
            chk("sweep_w_en", 32'(sram_w_en), 1);
            chk("sweep_w_addr", 32'(sram_w_addr), 32'(i));
            chk("sweep_w_data", 32'(sram_w_data), 0);
            chk("sweep_busy", 32'({init_done, wr_ready, rd_req_ready}), 0);
            @(negedge clock);
        end
        chk("init_done_32", 32'(init_done), 1);
        chk("post_sweep_w_en", 32'(sram_w_en), 0);
        chk("run_wr_ready", 32'(wr_ready), 1);
        chk("w_mask", 32'(sram_w_mask), 1);
        tick();

        rd(5'd0, 25'd0);
        rd(5'd17, 25'd0);
        rd(5'd31, 25'd0);
        wait_pops(3, "sweep_reads");

        // Write then read, latency of two cycles
        wr(5'd5, 25'h1ABCDEF);
        rd(5'd5, 25'h1ABCDEF);
        chk("lat_t1_valid", 32'(rd_resp_valid), 0);
        tick();
        chk("lat_t2_valid", 32'(rd_resp_valid), 1);
        chk("lat_t2_data", 32'(rd_resp_data), 32'h1ABCDEF);
        wait_pops(4, "lat_pop");

        // Back-to-back reads, no bubbles
        wr(5'd1, 25'h11);
        wr(5'd2, 25'h22);
        wr(5'd3, 25'h33);
        wr(5'd4, 25'h44);
        pop_cyc.delete();
        rd(5'd1, 25'h11);
        rd(5'd2, 25'h22);
        rd(5'd3, 25'h33);
        rd(5'd4, 25'h44);
        wait_pops(8, "b2b_pops");
        chk("b2b_span", 32'(pop_cyc[3] - pop_cyc[0]), 3);

        // Back-pressure: s1 and output fill, request side stalls
        rd_resp_ready = 1'b0;
        p0 = pops;
        rd(5'd1, 25'h11);
        rd(5'd2, 25'h22);
        chk("bp_req_ready_low", 32'(rd_req_ready), 0);
        fork
            begin
                rd(5'd3, 25'h33);
                rd(5'd4, 25'h44);
            end
        join_none
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            chk("bp_hold_valid", 32'(rd_resp_valid), 1);
            chk("bp_hold_data", 32'(rd_resp_data), 32'h11);
            chk("bp_hold_ready", 32'(rd_req_ready), 0);
        end
        tick();
        rd_resp_ready = 1'b1;
        wait_pops(p0 + 4, "bp_all_delivered");
        wait fork;
        repeat (3) tick();
        chk("bp_no_extra", 32'(pops - p0), 4);
        chk("bp_sb_empty", 32'(sb.size()), 0);

        // Stall with forwarding: latest write to the held address wins
        wr(5'd9, 25'h5);
        rd_resp_ready = 1'b0;
        p0 = pops;
        rd(5'd1, 25'h11);
        rd(5'd9, 25'h8);
        wr(5'd9, 25'h7);
        wr(5'd9, 25'h8);
        chk("fwd_hold_r_en", 32'(sram_r_en), 0);
        rd_resp_ready = 1'b1;
        wait_pops(p0 + 2, "fwd_pops");

        // Same-cycle read and write of one address: write-first
        rw(5'd12, 25'h3, 1'b1, 5'd12, 25'h3);
        wait_pops(p0 + 3, "same_cycle_pop");

        // Reset mid-sweep at address 10
        repeat (2) tick();
        reset_n = 1'b0;
        repeat (2) tick();
        @(negedge clock);
        reset_n = 1'b1;
        n = 0;
        while (sram_w_addr != 5'd10 && n < 40) begin
            n++;
            @(negedge clock);
        end
        chk("mid_reach_10", 32'(sram_w_addr), 10);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_w_en", 32'(sram_w_en), 0);
        chk("mid_rst_flags", 32'({init_done, wr_ready, rd_req_ready, rd_resp_valid, sram_r_en}), 0);
        tick();
        @(negedge clock);
        reset_n = 1'b1;
        #1;
        chk("restart_addr", 32'(sram_w_addr), 0);
        n = 0;
        for (int k = 0; k < 100; k++) begin
            if (init_done) break;
            if (sram_w_en) n++;
            @(negedge clock);
        end
        chk("restart_len", 32'(n), 32);
        chk("restart_done", 32'(init_done), 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
